// File: rtl/pc_gen.sv
// pc_gen: program counter with exception/redirect/stall priority and an optional
// circular return-address stack compiled in by defining PC_GEN_RAS_EN.
module pc_gen #(
    parameter int           N            = 32,
    parameter logic [N-1:0] RESET_VECTOR = '0,
    parameter logic [N-1:0] EXC_VECTOR   = N'(32'h0000_0080),
    parameter int           INC          = 4,
    parameter int           RAS_DEPTH    = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         n_EN,
    input  logic         exc_valid,
    input  logic         redirect_valid,
    input  logic [N-1:0] redirect_target,
    input  logic         call_push,
    input  logic         ret_pop,
    output logic [N-1:0] pc,
    output logic [N-1:0] pc_plus4,
    output logic         ras_empty,
    output logic         ras_full,
    output logic         ras_miss
);
    logic [N-1:0] pc_q, pc_d;
    logic         ret_hit;
    logic [N-1:0] ret_pc;

    assign pc       = pc_q;
    assign pc_plus4 = pc_q + N'(INC);

    always_comb begin
        pc_d = exc_valid      ? EXC_VECTOR :
               redirect_valid ? redirect_target :
               n_EN           ? pc_q :
               ret_hit        ? ret_pc : pc_plus4;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) pc_q <= RESET_VECTOR;
        else      pc_q <= pc_d;
    end

`ifdef PC_GEN_RAS_EN
    localparam int AW = $clog2(RAS_DEPTH);
    localparam int CW = AW + 1;
    logic [N-1:0]  stack_q [RAS_DEPTH];
    logic [N-1:0]  stack_d [RAS_DEPTH];
    logic [AW-1:0] top_q, top_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          miss_q, miss_d;
    logic          adv, do_push, do_pop;

    assign ras_empty = cnt_q == '0;
    assign ras_full  = cnt_q == CW'(RAS_DEPTH);
    assign ras_miss  = miss_q;
    assign ret_pc    = stack_q[top_q];

    // top_q points at the newest entry; a full push wraps onto the oldest slot
    always_comb begin
        adv      = !n_EN && !exc_valid && !redirect_valid;
        do_push  = adv && call_push;
        do_pop   = adv && ret_pop;
        ret_hit  = do_pop && !ras_empty;
        miss_d   = do_pop && ras_empty;
        stack_d  = stack_q;
        top_d    = top_q;
        cnt_d    = cnt_q;
        if (exc_valid) begin
            cnt_d = '0;
        end else if (do_push && ret_hit) begin
            stack_d[top_q] = pc_plus4;
        end else if (do_push) begin
            top_d          = top_q + AW'(1);
            stack_d[top_d] = pc_plus4;
            cnt_d          = ras_full ? cnt_q : cnt_q + CW'(1);
        end else if (ret_hit) begin
            top_d = top_q - AW'(1);
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            top_q  <= '0;
            cnt_q  <= '0;
            miss_q <= 1'b0;
        end else begin
            top_q  <= top_d;
            cnt_q  <= cnt_d;
            miss_q <= miss_d;
        end
    end

    always_ff @(posedge CLK) stack_q <= stack_d;
`else
    logic unused_ras;
    assign unused_ras = ^{call_push, ret_pop};
    assign ret_hit    = 1'b0;
    assign ret_pc     = '0;
    assign ras_empty  = 1'b1;
    assign ras_full   = 1'b0;
    assign ras_miss   = 1'b0;
`endif
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scoreboard bench for pc_gen; RAS scenarios run only when
// PC_GEN_RAS_EN is defined, otherwise the stack-disabled behaviour is checked.
module tb_pc_gen;
    typedef struct packed {
        logic [31:0] pc;
        logic        miss;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        n_EN = 1'b1, exc_valid = 1'b0, redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        call_push = 1'b0, ret_pop = 1'b0;
    logic [31:0] pc, pc_plus4;
    logic        ras_empty, ras_full, ras_miss;

    logic        n_en8 = 1'b1, red8 = 1'b0;
    logic [7:0]  tgt8 = '0;
    logic [7:0]  pc8, pp8;
    logic        e8, f8, m8;

    exp_t        sb [$];
    int          n_assert = 0;
    int          n_fail = 0;

    always #5 CLK = ~CLK;

    pc_gen u_dut (
        .CLK(CLK), .RST(RST), .n_EN(n_EN), .exc_valid(exc_valid),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .call_push(call_push), .ret_pop(ret_pop), .pc(pc), .pc_plus4(pc_plus4),
        .ras_empty(ras_empty), .ras_full(ras_full), .ras_miss(ras_miss)
    );

    pc_gen #(.N(8)) u_dut8 (
        .CLK(CLK), .RST(RST), .n_EN(n_en8), .exc_valid(1'b0),
        .redirect_valid(red8), .redirect_target(tgt8),
        .call_push(1'b0), .ret_pop(1'b0), .pc(pc8), .pc_plus4(pp8),
        .ras_empty(e8), .ras_full(f8), .ras_miss(m8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // drive one cycle of stimulus, queue the expectation, compare after the edge
    task automatic step(input string tag, input logic en_n, input logic exc, input logic red,
                        input logic [31:0] tgt, input logic push, input logic pop,
                        input logic [31:0] exp_pc, input logic exp_miss);
        exp_t e;
        n_EN = en_n; exc_valid = exc; redirect_valid = red;
        redirect_target = tgt; call_push = push; ret_pop = pop;
        sb.push_back('{pc: exp_pc, miss: exp_miss});
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        chk({tag, ".pc"}, pc, e.pc);
        chk({tag, ".miss"}, {31'b0, ras_miss}, {31'b0, e.miss});
        n_EN = 1'b1; exc_valid = 1'b0; redirect_valid = 1'b0; call_push = 1'b0; ret_pop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        chk("rst.pc", pc, 32'h0);
        chk("rst.pc_plus4", pc_plus4, 32'h4);
        chk("rst.empty", {31'b0, ras_empty}, 32'h1);
        chk("rst.full", {31'b0, ras_full}, 32'h0);
        chk("rst.miss", {31'b0, ras_miss}, 32'h0);
        RST = 1'b1;
        step("seq1", 0, 0, 0, 0, 0, 0, 32'h4, 0);
        step("seq2", 0, 0, 0, 0, 0, 0, 32'h8, 0);
        step("seq3", 0, 0, 0, 0, 0, 0, 32'hC, 0);
        step("stall1", 1, 0, 0, 0, 0, 0, 32'hC, 0);
        step("stall2", 1, 0, 0, 0, 0, 1, 32'hC, 0);
        step("redir_stall", 1, 0, 1, 32'h100, 0, 0, 32'h100, 0);
        step("exc_over_redir", 1, 1, 1, 32'h300, 0, 0, 32'h80, 0);
        step("wrap_set", 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 0);
        step("wrap", 0, 0, 0, 0, 0, 0, 32'h0, 0);
`ifdef PC_GEN_RAS_EN
        step("goto10", 0, 0, 1, 32'h10, 0, 0, 32'h10, 0);
        step("call", 0, 0, 0, 0, 1, 0, 32'h14, 0);
        chk("call.empty", {31'b0, ras_empty}, 32'h0);
        step("goto200", 0, 0, 1, 32'h200, 1, 1, 32'h200, 0);
        step("ret_hit", 0, 0, 0, 0, 0, 1, 32'h14, 0);
        chk("ret.empty", {31'b0, ras_empty}, 32'h1);
        step("goto200b", 0, 0, 1, 32'h200, 0, 0, 32'h200, 0);
        step("ret_miss", 0, 0, 0, 0, 0, 1, 32'h204, 1);
        step("miss_off", 0, 0, 0, 0, 0, 0, 32'h208, 0);
        step("goto0", 0, 0, 1, 32'h0, 0, 0, 32'h0, 0);
        for (int i = 1; i <= 5; i++) step("push", 0, 0, 0, 0, 1, 0, 32'(4 * i), 0);
        chk("push5.full", {31'b0, ras_full}, 32'h1);
        for (int i = 0; i < 4; i++) step("pop", 0, 0, 0, 0, 0, 1, 32'h14 - 32'(4 * i), 0);
        chk("pop4.empty", {31'b0, ras_empty}, 32'h1);
        chk("pop4.full", {31'b0, ras_full}, 32'h0);
        step("goto40", 0, 0, 1, 32'h40, 0, 0, 32'h40, 0);
        step("push44", 0, 0, 0, 0, 1, 0, 32'h44, 0);
        step("pushpop", 0, 0, 0, 0, 1, 1, 32'h44, 0);
        step("pop48", 0, 0, 0, 0, 0, 1, 32'h48, 0);
        step("pushpop_empty", 0, 0, 0, 0, 1, 1, 32'h4C, 1);
        chk("pushpop_empty.empty", {31'b0, ras_empty}, 32'h0);
        step("exc_clear", 0, 1, 0, 0, 1, 1, 32'h80, 0);
        chk("exc.empty", {31'b0, ras_empty}, 32'h1);
`else
        step("goto20", 0, 0, 1, 32'h20, 0, 0, 32'h20, 0);
        step("noras_pop", 0, 0, 0, 0, 1, 1, 32'h24, 0);
        chk("noras.empty", {31'b0, ras_empty}, 32'h1);
        chk("noras.full", {31'b0, ras_full}, 32'h0);
`endif
        red8 = 1'b1; tgt8 = 8'hFC; n_en8 = 1'b1;
        @(posedge CLK); #1;
        red8 = 1'b0; n_en8 = 1'b0;
        chk("n8.load", {24'b0, pc8}, 32'hFC);
        chk("n8.plus4", {24'b0, pp8}, 32'h0);
        @(posedge CLK); #1;
        chk("n8.wrap", {24'b0, pc8}, 32'h0);
        @(posedge CLK); #1;
        n_en8 = 1'b1;
        chk("n8.adv", {24'b0, pc8}, 32'h4);
        step("pre_rst", 0, 0, 1, 32'h500, 0, 0, 32'h500, 0);
        #2;
        n_EN = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h700;
        RST = 1'b0;
        #1;
        chk("async.pc", pc, 32'h0);
        chk("async.pc8", {24'b0, pc8}, 32'h0);
        chk("async.miss", {31'b0, ras_miss}, 32'h0);
        chk("async.empty", {31'b0, ras_empty}, 32'h1);
        @(posedge CLK); #1;
        chk("rst_hold.pc", pc, 32'h0);
        RST = 1'b1;
        step("post_rst", 0, 0, 0, 0, 0, 0, 32'h4, 0);
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
